// File: rtl/disp_scan.sv
// Multiplexed 7-segment scanner with a one-deep, frame-synchronous load buffer.
// Define DISP_SCAN_LZ_BLANK_EN to blank leading zero digits.
module disp_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load_valid,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    input  logic [NUM_DIGITS-1:0]     load_dp,
    output logic                      load_ready,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     seg_sel,
    output logic                      frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pcnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [NUM_DIGITS-1:0]   dp;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pending_full;

    logic                    slot_end;
    logic                    wrap;
    logic                    accept;
    logic [3:0]              nib;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
`ifdef DISP_SCAN_LZ_BLANK_EN
    logic                    zero_run;
`endif

    function automatic logic [6:0] seg7_hex(input logic [3:0] v);
        case (v)
            4'h0: seg7_hex = 7'h3F;
            4'h1: seg7_hex = 7'h06;
            4'h2: seg7_hex = 7'h5B;
            4'h3: seg7_hex = 7'h4F;
            4'h4: seg7_hex = 7'h66;
            4'h5: seg7_hex = 7'h6D;
            4'h6: seg7_hex = 7'h7D;
            4'h7: seg7_hex = 7'h07;
            4'h8: seg7_hex = 7'h7F;
            4'h9: seg7_hex = 7'h6F;
            4'hA: seg7_hex = 7'h77;
            4'hB: seg7_hex = 7'h7C;
            4'hC: seg7_hex = 7'h39;
            4'hD: seg7_hex = 7'h5E;
            4'hE: seg7_hex = 7'h79;
            default: seg7_hex = 7'h71;
        endcase
    endfunction

    assign slot_end   = enable && (pcnt == PCNT_LAST);
    assign wrap       = slot_end && (idx == IDX_LAST);
    assign load_ready = !pending_full;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (enable) begin
            if (pcnt == PCNT_LAST) begin
                pcnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // accept needs !pending_full, so it can never coincide with a frame-boundary copy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp         <= '0;
            dp           <= '0;
            pend_value   <= '0;
            pend_dp      <= '0;
            pending_full <= 1'b0;
        end else if (accept) begin
            pend_value   <= load_value;
            pend_dp      <= load_dp;
            pending_full <= 1'b1;
        end else if (wrap && pending_full) begin
            disp         <= pend_value;
            dp           <= pend_dp;
            pending_full <= 1'b0;
        end
    end

    always_comb begin
        nib       = '0;
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
`ifdef DISP_SCAN_LZ_BLANK_EN
        zero_run  = 1'b1;
`endif
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            nib = disp[4*(NUM_DIGITS-1-i) +: 4];
`ifdef DISP_SCAN_LZ_BLANK_EN
            zero_run = zero_run && (nib == 4'h0);
`endif
            if (idx == IW'(i)) begin
                cur_nib = nib;
                cur_dp  = dp[i];
`ifdef DISP_SCAN_LZ_BLANK_EN
                cur_blank = zero_run && (i != NUM_DIGITS - 1);
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg         <= '0;
            seg_sel     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (enable) begin
                seg_sel <= NUM_DIGITS'(1) << idx;
                seg     <= {cur_dp, cur_blank ? 7'h00 : seg7_hex(cur_nib)};
            end else begin
                seg_sel <= '0;
                seg     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan (4 digits, 4 clocks per slot) against a frame-level model.
module tb_disp_scan;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FRAME = ND * SD;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_value;
    logic [3:0]  load_dp;
    logic        load_ready;
    logic [7:0]  seg;
    logic [3:0]  seg_sel;
    logic        frame_start;

    disp_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_value  (load_value),
        .load_dp     (load_dp),
        .load_ready  (load_ready),
        .seg         (seg),
        .seg_sel     (seg_sel),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
    } load_t;

    // model: enabled clocks into the frame, shown value, pending buffer
    int          m_ticks;
    logic [15:0] m_disp;
    logic [3:0]  m_dpm;
    load_t       pend_q[$];
    logic [7:0]  e_seg;
    logic [3:0]  e_sel;
    logic        e_fs;

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dp;
        logic [0:3][7:0]  exp_seg;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic note_timeout(input string name);
        n_total++;
        $display("FAIL %s: timeout, got no event within budget at %0t", name, $time);
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    function automatic logic [7:0] model_seg(input int d);
        logic [15:0] upper;
        logic        blank;
        upper = m_disp >> (12 - 4*d);
        blank = 1'b0;
`ifdef DISP_SCAN_LZ_BLANK_EN
        blank = (d != ND-1) && (upper == 16'h0);
`endif
        return {m_dpm[d], blank ? 7'h00 : hex7(upper[3:0])};
    endfunction

    function automatic void model_clear();
        m_ticks = 0;
        m_disp  = '0;
        m_dpm   = '0;
        pend_q.delete();
        e_seg = '0;
        e_sel = '0;
        e_fs  = 1'b0;
    endfunction

    task automatic tick();
        bit    acc;
        int    d;
        load_t p;
        @(posedge clock);
        if (!reset) begin
            model_clear();
        end else begin
            acc = load_valid && (pend_q.size() == 0);
            if (enable) begin
                d     = m_ticks / SD;
                e_sel = 4'(1 << d);
                e_seg = model_seg(d);
                e_fs  = (m_ticks == FRAME-1);
                if (e_fs && pend_q.size() > 0) begin
                    p      = pend_q.pop_front();
                    m_disp = p.v;
                    m_dpm  = p.d;
                end
                m_ticks = (m_ticks + 1) % FRAME;
            end else begin
                e_sel = '0;
                e_seg = '0;
                e_fs  = 1'b0;
            end
            if (acc) pend_q.push_back('{v: load_value, d: load_dp});
        end
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("seg_sel", 32'(seg_sel), 32'(e_sel));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("load_ready", 32'(load_ready), 32'(pend_q.size() == 0));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (load_ready !== 1'b1 && n < budget) begin tick(); n++; end
        if (load_ready !== 1'b1) note_timeout("wait_ready");
    endtask

    task automatic wait_sel(input logic [3:0] target, input int budget);
        int n = 0;
        while (seg_sel !== target && n < budget) begin tick(); n++; end
        if (seg_sel !== target) note_timeout("wait_sel");
    endtask

    task automatic wait_fs(input int budget);
        int n = 0;
        do begin tick(); n++; end while (frame_start !== 1'b1 && n < budget);
        if (frame_start !== 1'b1) note_timeout("wait_fs");
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        wait_ready(2*FRAME + 4);
        load_valid = 1'b1;
        load_value = v;
        load_dp    = d;
        tick();
        load_valid = 1'b0;
        load_value = 16'($urandom);
        load_dp    = 4'($urandom);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        check("async_rst_seg", 32'(seg), 32'h0);
        check("async_rst_sel", 32'(seg_sel), 32'h0);
        check("async_rst_fs", 32'(frame_start), 32'h0);
        check("async_rst_ready", 32'(load_ready), 32'h1);
        model_clear();
        ticks(3);
        reset = 1'b1;
    endtask

    initial begin
        int   fs_cnt, fs_first;
        logic rdy_before, fs_prev;
        logic [7:0] lz_zero;

        tbl[0] = '{16'h12AF, 4'b0100, {8'h06, 8'h5B, 8'hF7, 8'h71}};
`ifdef DISP_SCAN_LZ_BLANK_EN
        tbl[1] = '{16'h0005, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h6D}};
        tbl[4] = '{16'h0000, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h3F}};
        tbl[5] = '{16'h07D0, 4'b0001, {8'h80, 8'h07, 8'h5E, 8'h3F}};
        lz_zero = 8'h00;
`else
        tbl[1] = '{16'h0005, 4'b0000, {8'h3F, 8'h3F, 8'h3F, 8'h6D}};
        tbl[4] = '{16'h0000, 4'b0000, {8'h3F, 8'h3F, 8'h3F, 8'h3F}};
        tbl[5] = '{16'h07D0, 4'b0001, {8'hBF, 8'h07, 8'h5E, 8'h3F}};
        lz_zero = 8'h3F;
`endif
        tbl[2] = '{16'h8E3C, 4'b1001, {8'hFF, 8'h79, 8'h4F, 8'hB9}};
        tbl[3] = '{16'h4B96, 4'b0010, {8'h66, 8'hFC, 8'h6F, 8'h7D}};
        tbl[6] = '{16'h3040, 4'b0000, {8'h4F, 8'h3F, 8'h66, 8'h3F}};

        reset      = 1'b0;
        enable     = 1'b1;
        load_valid = 1'b0;
        load_value = '0;
        load_dp    = '0;
        model_clear();
        ticks(3);
        reset = 1'b1;

        // scan order and frame period after reset release
        fs_cnt = 0;
        fs_first = -1;
        for (int k = 1; k <= 2*FRAME; k++) begin
            tick();
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
            end
            if (k == 1)  check("scan_d0", 32'(seg_sel), 32'b0001);
            if (k == 5)  check("scan_d1", 32'(seg_sel), 32'b0010);
            if (k == 9)  check("scan_d2", 32'(seg_sel), 32'b0100);
            if (k == 13) check("scan_d3", 32'(seg_sel), 32'b1000);
        end
        check("fs_count", 32'(fs_cnt), 32'd2);
        check("fs_first", 32'(fs_first), 32'd16);

        // decode table: each value shows from the frame after its accept
        for (int i = 0; i < 7; i++) begin
            load(tbl[i].value, tbl[i].dp);
            check($sformatf("tbl%0d_busy", i), 32'(load_ready), 32'h0);
            wait_ready(2*FRAME + 4);
            tick();
            for (int d = 0; d < ND; d++) begin
                check($sformatf("tbl%0d_dig%0d", i, d), 32'(seg), 32'(tbl[i].exp_seg[d]));
                if (d < ND-1) ticks(SD);
            end
        end

        // load_valid held high across two values
        wait_ready(2*FRAME + 4);
        load_valid = 1'b1;
        load_value = 16'h1111;
        load_dp    = 4'b0000;
        for (int n = 0; n < 4*FRAME; n++) begin
            rdy_before = load_ready;
            tick();
            if (rdy_before) break;
        end
        load_value = 16'h2222;
        fs_prev = 1'b0;
        rdy_before = 1'b0;
        for (int n = 0; n < 4*FRAME && !rdy_before; n++) begin
            rdy_before = load_ready;
            fs_prev = frame_start;
            tick();
        end
        load_valid = 1'b0;
        if (!rdy_before) note_timeout("hold_second_accept");
        check("hold_accept_after_wrap", 32'(fs_prev), 32'h1);
        check("hold_first_shown", 32'(seg), 32'h06);

        // accept landing exactly on the wrap edge waits a full frame
        wait_fs(2*FRAME + 4);
        ticks(FRAME - 1);
        load_valid = 1'b1;
        load_value = 16'h5A5A;
        load_dp    = 4'b0001;
        tick();
        load_valid = 1'b0;
        check("wrapacc_fs", 32'(frame_start), 32'h1);
        check("wrapacc_ready", 32'(load_ready), 32'h0);
        tick();
        check("wrapacc_old_frame", 32'(seg), 32'h5B);
        ticks(FRAME - 1);
        check("wrapacc_fs2", 32'(frame_start), 32'h1);
        tick();
        check("wrapacc_new_frame", 32'(seg), 32'hED);

        // enable low for 10 clocks inside digit 2
        wait_sel(4'b0100, 2*FRAME);
        tick();
        enable = 1'b0;
        ticks(10);
        check("pause_sel", 32'(seg_sel), 32'h0);
        check("pause_seg", 32'(seg), 32'h0);
        enable = 1'b1;
        tick();
        check("resume_1", 32'(seg_sel), 32'b0100);
        tick();
        check("resume_2", 32'(seg_sel), 32'b0100);
        tick();
        check("resume_3", 32'(seg_sel), 32'b1000);

        // reset while a value is pending discards it
        load(16'hABCD, 4'b1111);
        check("pend_busy", 32'(load_ready), 32'h0);
        ticks(2);
        reset_pulse();
        wait_fs(2*FRAME + 4);
        wait_fs(2*FRAME + 4);
        tick();
        check("pend_discarded", 32'(seg), 32'(lz_zero));

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            load_value = 16'($urandom);
            load_dp    = 4'($urandom);
            if (i == 700) reset_pulse();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
